spi_slave_core: RTL
===================

# spi_slave_core

Parametrised SPI slave core that generalises the fixed 32-bit, single-mode slave. It adds a configurable word width, all four SPI modes (CPOL/CPHA), MSB- or LSB-first ordering, and a parallel TX/RX datapath with a valid/ready handshake. It oversamples SCLK in the `clk` domain, supports back-to-back words under one `ss` assertion, and reports underrun and framing errors. It sits between the SPI pins and the register/DMA logic that supplies and consumes words.

## Interface
- `DATA_WIDTH`, default 32: bits per SPI word, ≥2.
- `MSB_FIRST`, default 1: 1 = MSB shifted first on both MOSI and MISO; 0 = LSB first.
- `SYNC_STAGES`, default 2: synchroniser depth for `ss`/`sclk`/`mosi`, ≥2.
- Count width is derived as `$clog2(DATA_WIDTH+1)`; it is not a parameter.

- `clk` in 1: system clock. One clock; the `clk` frequency must be ≥ 8× the SCLK frequency.
- `reset_n` in 1: asynchronous, active-low reset.
- `ss` in 1: slave select, active-low, asynchronous to `clk`.
- `sclk` in 1: SPI clock, asynchronous to `clk`.
- `mosi` in 1: serial data in.
- `cpol`, `cpha` in 1 each: SPI mode select, latched on the `ss` falling edge.
- `miso` out 1: serial data out.
- `miso_oe` out 1: MISO output enable; high while the synchronised `ss` is low.
- `tx_data` in DATA_WIDTH: next word to transmit.
- `tx_valid` in 1, `tx_ready` out 1: TX handshake into the 1-deep TX buffer.
- `rx_data` out DATA_WIDTH: last complete received word; held until the next word completes.
- `rx_valid` out 1: 1-cycle pulse when `rx_data` updates.
- `busy` out 1: FSM is in ACTIVE.
- `tx_underrun` out 1: 1-cycle pulse.
- `frame_err` out 1: 1-cycle pulse.

## Operation
- **Synchronisation.** `ss`, `sclk` and `mosi` each pass through SYNC_STAGES flip-flops.
  - `sclk_d` is the synchronised `sclk` delayed by one cycle.
  - `rise` = `sclk_s & ~sclk_d`; `fall` = `~sclk_s & sclk_d`.
  - `ss_fall` and `ss_rise` are derived the same way from the synchronised `ss`.
- **Edge roles.** The leading edge is `rise` when `cpol`=0, `fall` when `cpol`=1.
  - `cpha`=0: sample on the leading edge, shift on the trailing edge.
  - `cpha`=1: sample on the trailing edge, shift on the leading edge.
- **TX buffer.** 1-deep; `tx_ready` = buffer empty.
  - `tx_valid & tx_ready` writes the buffer.
  - A word load takes the buffer contents and empties it.
  - If the buffer is empty but `tx_valid`=1 in the load cycle, the load takes `tx_data` directly (bypass) and the handshake completes.
  - If no word is available, the load uses all zeros and pulses `tx_underrun`.
- **FSM states: IDLE, ACTIVE.**
- IDLE, on `ss_fall`:
  - latch `cpol`/`cpha`;
  - load `tx_shift`;
  - set `cnt`=0, `reload_pend`=0, `skip`=`cpha`;
  - go to ACTIVE.
- ACTIVE, on a sample edge:
  - shift `mosi_s` into `rx_shift` (toward LSB if MSB_FIRST, else toward MSB);
  - `cnt`++.
- ACTIVE, when `cnt` reaches DATA_WIDTH on a sample edge:
  - `rx_data` ← completed word (including this bit);
  - pulse `rx_valid`;
  - set `cnt`=0, `reload_pend`=1.
- ACTIVE, on a shift edge:
  - if `reload_pend`: load `tx_shift` (buffer/bypass/zeros rule) and clear `reload_pend`;
  - else if `skip`: clear `skip` (keeps bit 0 on the line for the CPHA=1 first edge);
  - else: shift `tx_shift`.
- ACTIVE, on `ss_rise`:
  - go to IDLE;
  - if `cnt`≠0, pulse `frame_err` and discard the partial RX word;
  - a partially sent TX word is dropped, not re-queued.
  - If `ss_rise` and a final sample edge occur in the same cycle, the edge is processed first: the word completes and `rx_valid` pulses with no `frame_err`.
- **MISO output.** `miso` = `tx_shift[DATA_WIDTH-1]` if MSB_FIRST, else `tx_shift[0]`. It is registered and drives 0 in IDLE.
- **Width rules.** `cnt` never exceeds DATA_WIDTH. Sample and shift edges are mutually exclusive for a given mode.

## Timing
- **Reset values.**
  - 0: `miso`, `miso_oe`, `rx_data`, `rx_valid`, `busy`, `tx_underrun`, `frame_err`.
  - 1: `tx_ready` (buffer empty).
  - Internal: FSM = IDLE.
- **Pin-to-effect latency.** A pin transition is visible in registered outputs SYNC_STAGES+1 `clk` edges later (3 with defaults).
  - This covers `miso` updating after a shift edge and `rx_valid` after the final sample edge.
- **`rx_valid`** is high for exactly one cycle per word. There is no backpressure; an unread word is overwritten by the next.
- **`tx_ready`** rises the cycle after a load empties the buffer.
- **CPHA=0 first bit.** Bit 0 is on `miso` SYNC_STAGES+1 edges after `ss` falls. The master must allow ≥4 `clk` cycles before the first SCLK edge.
- **Reset mid-transfer.** Everything returns immediately to the reset values. The transfer is not resumed.

## Test plan
- **Mode 0, MSB first, W=32.** Buffer 0xA5A5_1234; master sends 0xDEAD_BEEF. Required: MISO bits equal 0xA5A5_1234; `rx_data`=0xDEAD_BEEF; one `rx_valid` pulse; `tx_ready` high again after the load.
- **Modes 1, 2, 3 with W=8, MSB_FIRST=0.** Master sends 0x3C; buffer 0x81. Required: `rx_data`=0x3C and MISO returns 0x81, LSB first, in every mode.
- **Back-to-back words.** Three words 0x11, 0x22, 0x33 under one `ss` assertion (W=8); buffer refilled after each `tx_ready`. Required: three `rx_valid` pulses, no `tx_underrun`, MISO streams 0x11, 0x22, 0x33.
- **Underrun.** Empty buffer and `tx_valid`=0 at `ss` fall. Required: `tx_underrun` pulses once; MISO is all zeros; RX still completes.
- **Abort.** `ss` rises after 5 of 8 bits. Required: `frame_err` pulses once; no `rx_valid`; `rx_data` keeps its old value; the next full frame is received correctly.
- **Async reset mid-word.** `reset_n` low for 1 cycle after bit 3. Required: all outputs at reset values; `tx_ready`=1; the next frame starting on a fresh `ss` fall is correct.

Source files
------------

// File: rtl/spi_slave_core.sv
// spi_slave_core: parametrised SPI slave that oversamples the SPI pins in the
// clk domain. It supports all four SPI modes, MSB- or LSB-first ordering, and
// back-to-back words under one ss assertion. It has a 1-deep TX buffer with a
// valid/ready handshake.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   ss, sclk, mosi      SPI pins (asynchronous, synchronised internally)
//   cpol, cpha          SPI mode, latched when ss falls
//   miso, miso_oe       serial data out and its output enable
//   tx_data, tx_valid,  word to transmit and handshake into the TX buffer
//   tx_ready
//   rx_data, rx_valid   last complete received word, 1-cycle update pulse
//   busy                a frame is in progress (ss asserted)
//   tx_underrun         1-cycle pulse: a word load found no data
//   frame_err           1-cycle pulse: ss rose in the middle of a word
module spi_slave_core #(
   parameter int DATA_WIDTH  = 32,
   parameter bit MSB_FIRST   = 1'b1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ss,
   input  logic                  sclk,
   input  logic                  mosi,
   input  logic                  cpol,
   input  logic                  cpha,
   output logic                  miso,
   output logic                  miso_oe,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  tx_underrun,
   output logic                  frame_err
);

   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   // ---------------- pin synchronisers and edge detect ----------------
   // ss resets high (deasserted) so that leaving reset never looks like a
   // falling ss edge.
   logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
   logic                   ss_d, sclk_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ss_sync   <= '1;
         sclk_sync <= '0;
         mosi_sync <= '0;
         ss_d      <= 1'b1;
         sclk_d    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let each stage take the previous
         // stage's old value, which is what forms the shift chain.
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         ss_d      <= ss_sync[SYNC_STAGES-1];
         sclk_d    <= sclk_sync[SYNC_STAGES-1];
      end
   end

   logic ss_s, sclk_s, mosi_s;
   logic rise, fall, ss_fall, ss_rise;
   assign ss_s    = ss_sync[SYNC_STAGES-1];
   assign sclk_s  = sclk_sync[SYNC_STAGES-1];
   assign mosi_s  = mosi_sync[SYNC_STAGES-1];
   assign rise    =  sclk_s & ~sclk_d;
   assign fall    = ~sclk_s &  sclk_d;
   assign ss_fall = ~ss_s &  ss_d;
   assign ss_rise =  ss_s & ~ss_d;

   // ---------------- state ----------------
   state_t                state_q, state_n;
   logic                  cpol_q, cpol_n, cpha_q, cpha_n;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_n;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_n;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_n;
   logic [DATA_WIDTH-1:0] buf_q, buf_n;
   logic                  buf_full_q, buf_full_n;
   logic [CW-1:0]         cnt_q, cnt_n;
   logic                  reload_q, reload_n, skip_q, skip_n;
   logic                  miso_q, miso_n;
   logic                  rx_valid_q, rx_valid_n;
   logic                  underrun_q, underrun_n;
   logic                  frame_err_q, frame_err_n;
   logic                  load;

   // The leading edge leaves the idle level; CPHA picks which edge samples.
   logic lead, trail, sample_e, shift_e;
   assign lead     = cpol_q ? fall : rise;
   assign trail    = cpol_q ? rise : fall;
   assign sample_e = cpha_q ? trail : lead;
   assign shift_e  = cpha_q ? lead  : trail;

   always_comb begin
      // NOTE: every variable gets a default first, so no path through this
      // block leaves one unassigned and no latch is inferred.
      state_n     = state_q;
      cpol_n      = cpol_q;
      cpha_n      = cpha_q;
      tx_shift_n  = tx_shift_q;
      rx_shift_n  = rx_shift_q;
      rx_data_n   = rx_data_q;
      buf_n       = buf_q;
      buf_full_n  = buf_full_q;
      cnt_n       = cnt_q;
      reload_n    = reload_q;
      skip_n      = skip_q;
      rx_valid_n  = 1'b0;
      underrun_n  = 1'b0;
      frame_err_n = 1'b0;
      load        = 1'b0;

      case (state_q)
         IDLE: begin
            if (ss_fall) begin
               cpol_n   = cpol;
               cpha_n   = cpha;
               load     = 1'b1;
               cnt_n    = '0;
               reload_n = 1'b0;
               skip_n   = cpha;
               state_n  = ACTIVE;
            end
         end
         ACTIVE: begin
            if (sample_e) begin
               rx_shift_n = MSB_FIRST ? {rx_shift_q[DATA_WIDTH-2:0], mosi_s}
                                      : {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};
               if (cnt_q == CNT_LAST) begin
                  rx_data_n  = rx_shift_n;
                  rx_valid_n = 1'b1;
                  cnt_n      = '0;
                  reload_n   = 1'b1;
               end else begin
                  cnt_n = cnt_q + 1'b1;
               end
            end else if (shift_e && !ss_rise) begin
               // A shift edge that coincides with the end of the frame is
               // ignored, so it cannot consume the buffer for a dead frame.
               if (reload_q) begin
                  load     = 1'b1;
                  reload_n = 1'b0;
               end else if (skip_q) begin
                  skip_n = 1'b0;   // CPHA=1: bit 0 is already on the line
               end else begin
                  tx_shift_n = MSB_FIRST ? (tx_shift_q << 1) : (tx_shift_q >> 1);
               end
            end
            // The edge above is handled first, so a word finishing in this
            // same cycle has already cleared cnt and is not a framing error.
            if (ss_rise) begin
               state_n = IDLE;
               if (cnt_n != '0) frame_err_n = 1'b1;
               cnt_n    = '0;
               reload_n = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase

      // TX buffer: a load takes the buffer, else bypasses tx_data, else zeros.
      if (load) begin
         if (buf_full_q) begin
            tx_shift_n = buf_q;
            buf_full_n = 1'b0;
         end else if (tx_valid) begin
            tx_shift_n = tx_data;
         end else begin
            tx_shift_n = '0;
            underrun_n = 1'b1;
         end
      end else if (tx_valid && !buf_full_q) begin
         buf_n      = tx_data;
         buf_full_n = 1'b1;
      end

      miso_n = (state_n == ACTIVE)
               ? (MSB_FIRST ? tx_shift_n[DATA_WIDTH-1] : tx_shift_n[0])
               : 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         tx_shift_q  <= '0;
         rx_shift_q  <= '0;
         rx_data_q   <= '0;
         buf_q       <= '0;
         buf_full_q  <= 1'b0;
         cnt_q       <= '0;
         reload_q    <= 1'b0;
         skip_q      <= 1'b0;
         miso_q      <= 1'b0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_n;
         cpol_q      <= cpol_n;
         cpha_q      <= cpha_n;
         tx_shift_q  <= tx_shift_n;
         rx_shift_q  <= rx_shift_n;
         rx_data_q   <= rx_data_n;
         buf_q       <= buf_n;
         buf_full_q  <= buf_full_n;
         cnt_q       <= cnt_n;
         reload_q    <= reload_n;
         skip_q      <= skip_n;
         miso_q      <= miso_n;
         rx_valid_q  <= rx_valid_n;
         underrun_q  <= underrun_n;
         frame_err_q <= frame_err_n;
      end
   end

   assign miso        = miso_q;
   assign miso_oe     = ~ss_s;
   assign tx_ready    = ~buf_full_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign busy        = (state_q == ACTIVE);
   assign tx_underrun = underrun_q;
   assign frame_err   = frame_err_q;

endmodule
